dmem_block_responder: RTL
=========================

# dmem_block_responder

Block-granular main-memory responder for the L1 data cache. Sits on the memory side of the cache-controller/memory interface. Accepts one block read (`memRen`) or block write (`memWen`) at a time, models a fixed access latency with a counter-driven FSM, and completes each request with a one-cycle `memReadReady` or `memWriteDone` pulse. It holds the backing store for `2^BLOCK_ADDR_WIDTH` blocks.

## Interface
Parameters:
- `BLOCK_ADDR_WIDTH`, default 8: block address width; depth = `2^BLOCK_ADDR_WIDTH` blocks.
- `BLOCK_BITS`, default 128: block width in bits.
- `LATENCY`, default 4: cycles spent in BUSY; legal range 1..255.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memRen` in 1: block read request, level, held by the requester until `memReadReady`.
- `memWen` in 1: block write request, level, held until `memWriteDone`.
- `BlockAddr` in `BLOCK_ADDR_WIDTH`: block address, sampled at accept.
- `memDin` in `BLOCK_BITS`: write block, sampled at accept.
- `memDout` out `BLOCK_BITS`: read block, registered.
- `memReadReady` out 1: one-cycle read completion pulse.
- `memWriteDone` out 1: one-cycle write completion pulse.
- `protErr` out 1: sticky protocol-error flag (see Configuration).

## Operation
- FSM states: IDLE, BUSY, RESP. The design also holds a latched op flag (read/write), a latched address, a latched write data register, and an 8-bit down-counter.
- IDLE:
  - If `memWen` is high, latch op=write, `BlockAddr` and `memDin`, load counter=`LATENCY-1`, and go to BUSY.
  - Else if `memRen` is high, latch op=read and the address, and go to BUSY.
  - Else stay in IDLE.
  - Write has priority when both requests are high.
- BUSY: decrement the counter each cycle. When the counter is 0, go to RESP at that edge.
  - For a read, the same edge loads `memDout` from the array at the latched address.
- RESP, one cycle only:
  - `memReadReady` = op==read; `memWriteDone` = op==write.
  - For a write, the array is written with the latched data at the edge that ends RESP.
  - Next state is always IDLE.
- Requests are latched: the request and its inputs are not re-sampled after accept. A request that drops during BUSY still completes, including the pulse and the write.
- `memDout` holds its value until the next read completes. Writes never change `memDout`.
- The array is not reset; its contents are undefined until written. The simulation model initialises it to zero.

## Timing
- Reset values (asynchronous):
  - state=IDLE
  - `memDout`=0
  - `memReadReady`=0
  - `memWriteDone`=0
  - `protErr`=0
  - counter=0
- Latency: a request first high in cycle N gives its completion pulse in cycle N+LATENCY+1. `memDout` is valid from that same cycle.
- Pulse outputs are registered, being decoded from the registered state, and are high for exactly one cycle.
- Back-to-back requests: IDLE is re-entered in cycle N+LATENCY+2 and can accept a request in that same cycle. This covers the writeback-then-read sequence, where `memRen` is raised in the cycle after `memWriteDone`.
- Read-after-write to the same block returns the new data. The write commits at the end of RESP, before the following IDLE accept.
- A request that stays high through and after its completion pulse is treated as a new request in IDLE.
- Reset asserted mid-operation:
  - The FSM returns to IDLE and no pulse is produced.
  - A pending write is discarded and the array is unchanged.

## Configuration
- Macro `DMEM_PROTOCOL_CHECK_EN`.
- When defined, `protErr` is set and stays set until reset if any of the following occurs:
  - (a) `memRen` and `memWen` are both high in any cycle;
  - (b) the latched request signal goes low during BUSY before its completion pulse;
  - (c) `BlockAddr` changes while the latched request is still high during BUSY.
- When not defined, `protErr` is tied to 0 and the checking logic is absent. Functional behaviour is identical in both builds.

## Test plan
- Reset then read, with LATENCY=4 and `memRen` high from cycle 1 at addr 0x05 after a write of 0xA5A5... to it:
  - `memReadReady` high in cycle 6 only;
  - `memDout`=0xA5A5... from cycle 6 on.
- Writeback then read sequence: write 0x1111... to 0x10, then read 0x10 raised in the cycle after `memWriteDone`:
  - read is accepted immediately;
  - `memReadReady` arrives 5 cycles later with 0x1111....
- `memRen` and `memWen` both high with addr 0x20 and din 0x2222...:
  - write completes first (`memWriteDone`);
  - the read is served afterward and returns 0x2222...;
  - `protErr`=1 only when the macro is defined.
- `memWen` dropped after 1 cycle of BUSY:
  - `memWriteDone` still pulses at N+5;
  - the array is updated;
  - `protErr`=1 under the macro.
- Reset pulsed low during BUSY of a write to 0x30:
  - no `memWriteDone`;
  - all outputs are 0;
  - a later read of 0x30 returns its prior contents.

Source files
------------

// File: rtl/dmem_block_responder.sv
// Block-granular main-memory responder for the L1 data cache memory side.
// Ports: clock, reset (async active-low), memRen/memWen level requests,
//   BlockAddr, memDin in; memDout, memReadReady, memWriteDone, protErr out.
// Optional checker: define DMEM_PROTOCOL_CHECK_EN to drive a sticky protErr.
module dmem_block_responder #(
    parameter int BLOCK_ADDR_WIDTH = 8,
    parameter int BLOCK_BITS       = 128,
    parameter int LATENCY          = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        memRen,
    input  logic                        memWen,
    input  logic [BLOCK_ADDR_WIDTH-1:0] BlockAddr,
    input  logic [BLOCK_BITS-1:0]       memDin,
    output logic [BLOCK_BITS-1:0]       memDout,
    output logic                        memReadReady,
    output logic                        memWriteDone,
    output logic                        protErr
);

    localparam int         DEPTH  = 1 << BLOCK_ADDR_WIDTH;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        op_wr_q;
    logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
    logic [BLOCK_BITS-1:0]       wdata_q;
    logic [7:0]                  cnt_q;
    logic [BLOCK_BITS-1:0]       mem [DEPTH];

    logic accept;
    logic done;

    assign accept = (state_q == IDLE) && (memWen || memRen);
    assign done   = (state_q == BUSY) && (cnt_q == 8'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (memWen || memRen) state_d = BUSY;
            BUSY: if (cnt_q == 8'd0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is captured once at accept; nothing is re-sampled later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 8'd0;
            memDout      <= '0;
            memReadReady <= 1'b0;
            memWriteDone <= 1'b0;
        end else begin
            if (accept) begin
                op_wr_q <= memWen;
                addr_q  <= BlockAddr;
                cnt_q   <= LAT_M1;
                if (memWen) wdata_q <= memDin;
            end else if (state_q == BUSY && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
            // Pulses are flops set on the BUSY->RESP edge, so they
            // track the registered RESP state exactly.
            memReadReady <= done && !op_wr_q;
            memWriteDone <= done && op_wr_q;
            if (done && !op_wr_q) memDout <= mem[addr_q];
        end
    end

    // Commit at the edge leaving RESP so a read accepted next sees it.
    always_ff @(posedge clock) begin
        if (state_q == RESP && op_wr_q) mem[addr_q] <= wdata_q;
    end

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic req_lat;
    logic err_now;
    logic err_q;

    assign req_lat = op_wr_q ? memWen : memRen;
    assign err_now = (memRen && memWen) ||
                     ((state_q == BUSY) && !req_lat) ||
                     ((state_q == BUSY) && req_lat && (BlockAddr != addr_q));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign protErr = err_q;
`else
    assign protErr = 1'b0;
`endif

endmodule
